// File: rtl/qctrl_pkg.sv
// Shared types and default sizing for the tProc start/reset sequencer.
package qctrl_pkg;

  typedef enum logic [1:0] {
    QC_IDLE  = 2'd0,
    QC_WSYNC = 2'd1,
    QC_EXEC  = 2'd2,
    QC_ACK   = 2'd3
  } qc_state_e;

  localparam int unsigned QC_N_CH    = 4;
  localparam int unsigned QC_PULSE_W = 8;
  localparam int unsigned QC_SKIP_W  = 4;
  localparam int unsigned QC_TOUT_W  = 16;

endpackage

// File: rtl/sync_reg.sv
// Two-flop synchroniser for signals crossing into the local clock domain.
module sync_reg #(
  parameter int DW = 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] dt_i,
  output logic [DW-1:0] dt_o
);

  logic [DW-1:0] meta_q;
  logic [DW-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= dt_i;
      sync_q <= meta_q;
    end
  end

  assign dt_o = sync_q;

endmodule

// File: rtl/qctrl_seq.sv
// tProc start/reset sequencer: immediate or sync-aligned start pulse on a
// masked set of channels, acknowledged with a four-phase handshake.
module qctrl_seq
  import qctrl_pkg::*;
#(
  parameter int N_CH    = QC_N_CH,
  parameter int PULSE_W = QC_PULSE_W,
  parameter int SKIP_W  = QC_SKIP_W,
  parameter int TOUT_W  = QC_TOUT_W
) (
  input  logic               t_clk_i,
  input  logic               t_rst_ni,
  input  logic               pulse_sync_i,
  input  logic               qrst_req_i,
  input  logic               qsync_req_i,
  input  logic [N_CH-1:0]    ch_mask_i,
  input  logic [PULSE_W-1:0] pulse_len_i,
  input  logic [SKIP_W-1:0]  sync_skip_i,
  input  logic [TOUT_W-1:0]  tout_i,
  output logic               qrst_ack_o,
  output logic               busy_o,
  output logic               tout_o,
  output logic [N_CH-1:0]    qproc_start_o
);

  logic sync_s;
  logic sync_prev_q;
  logic sync_rise;

  sync_reg #(.DW(1)) u_sync (
    .clk_i  (t_clk_i),
    .rstn_i (t_rst_ni),
    .dt_i   (pulse_sync_i),
    .dt_o   (sync_s)
  );

  assign sync_rise = sync_s & ~sync_prev_q;

  qc_state_e          state_q, state_d;
  logic [N_CH-1:0]    mask_q, mask_d;
  logic [PULSE_W-1:0] len_q, len_d;
  logic [PULSE_W-1:0] pcnt_q, pcnt_d;
  logic [SKIP_W-1:0]  skip_q, skip_d;
  logic [TOUT_W-1:0]  tout_q, tout_d;
  logic [TOUT_W-1:0]  tcnt_q, tcnt_d, tcnt_inc;
  logic               tflag_q, tflag_d;
  logic [N_CH-1:0]    start_q, start_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               req_any;

  assign req_any  = qsync_req_i | qrst_req_i;
  assign tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + TOUT_W'(1);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    len_d   = len_q;
    pcnt_d  = pcnt_q;
    skip_d  = skip_q;
    tout_d  = tout_q;
    tcnt_d  = tcnt_q;
    tflag_d = tflag_q;

    case (state_q)
      QC_IDLE: begin
        if (req_any) begin
          mask_d  = ch_mask_i;
          len_d   = (pulse_len_i == '0) ? PULSE_W'(1) : pulse_len_i;
          skip_d  = sync_skip_i;
          tout_d  = tout_i;
          tcnt_d  = '0;
          pcnt_d  = PULSE_W'(1);
          tflag_d = 1'b0;
          state_d = qsync_req_i ? QC_WSYNC : QC_EXEC;
        end
      end
      QC_WSYNC: begin
        tcnt_d = tcnt_inc;
        // Abort beats a sync edge, and a sync edge beats the timeout.
        if (!req_any) begin
          state_d = QC_IDLE;
        end else if (sync_rise) begin
          if (skip_q == '0) begin
            state_d = QC_EXEC;
            pcnt_d  = PULSE_W'(1);
          end else begin
            skip_d = skip_q - SKIP_W'(1);
          end
        end else if ((tout_q != '0) && (tcnt_inc == tout_q)) begin
          state_d = QC_ACK;
          tflag_d = 1'b1;
        end
      end
      QC_EXEC: begin
        if (pcnt_q == len_q) begin
          state_d = QC_ACK;
        end else begin
          pcnt_d = pcnt_q + PULSE_W'(1);
        end
      end
      QC_ACK: begin
        if (!req_any) state_d = QC_IDLE;
      end
      default: state_d = QC_IDLE;
    endcase

    // Outputs are decoded from the next state so they move with the state register.
    start_d = (state_d == QC_EXEC) ? mask_d : '0;
    ack_d   = (state_d != QC_IDLE);
    busy_d  = (state_d != QC_IDLE);
  end

  always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
    if (!t_rst_ni) begin
      state_q     <= QC_IDLE;
      mask_q      <= '0;
      len_q       <= '0;
      pcnt_q      <= '0;
      skip_q      <= '0;
      tout_q      <= '0;
      tcnt_q      <= '0;
      tflag_q     <= 1'b0;
      start_q     <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      len_q       <= len_d;
      pcnt_q      <= pcnt_d;
      skip_q      <= skip_d;
      tout_q      <= tout_d;
      tcnt_q      <= tcnt_d;
      tflag_q     <= tflag_d;
      start_q     <= start_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      sync_prev_q <= sync_s;
    end
  end

  assign qproc_start_o = start_q;
  assign qrst_ack_o    = ack_q;
  assign busy_o        = busy_q;
  assign tout_o        = tflag_q;

endmodule

// File: tb/tb_qctrl_seq.sv
// Self-checking bench for qctrl_seq: directed scenarios plus random traffic
// against a countdown-style behavioural model.
module tb_qctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps = 1'b0;
  logic        qrst = 1'b0;
  logic        qsync = 1'b0;
  logic [3:0]  mask = '0;
  logic [7:0]  len = '0;
  logic [3:0]  skip = '0;
  logic [15:0] tout = '0;
  logic        ack, busy, tflag;
  logic [3:0]  start;

  int n_tests = 0;
  int n_fail  = 0;

  qctrl_seq dut (
    .t_clk_i       (clk),
    .t_rst_ni      (rst_n),
    .pulse_sync_i  (ps),
    .qrst_req_i    (qrst),
    .qsync_req_i   (qsync),
    .ch_mask_i     (mask),
    .pulse_len_i   (len),
    .sync_skip_i   (skip),
    .tout_i        (tout),
    .qrst_ack_o    (ack),
    .busy_o        (busy),
    .tout_o        (tflag),
    .qproc_start_o (start)
  );

  always #5 clk = ~clk;

  // Behavioural model: counts remaining work down rather than tracking states.
  bit         m_busy, m_wait, m_flag;
  int         m_pulse_left, m_len, m_edges_left, m_elapsed, m_limit;
  logic [3:0] m_mask;
  bit         h0, h1, h2;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_wait = 0; m_flag = 0; m_pulse_left = 0; m_len = 0;
        m_edges_left = 0; m_elapsed = 0; m_limit = 0; m_mask = '0;
        h0 = 0; h1 = 0; h2 = 0;
      end else begin
        bit rise;
        rise = h1 && !h2;
        h2 = h1; h1 = h0; h0 = ps;
        if (!m_busy) begin
          if (qsync || qrst) begin
            m_busy = 1; m_flag = 0; m_mask = mask;
            m_len = (len == 0) ? 1 : int'(len);
            m_edges_left = int'(skip) + 1;
            m_limit = int'(tout); m_elapsed = 0;
            if (qsync) m_wait = 1;
            else m_pulse_left = m_len;
          end
        end else if (m_wait) begin
          m_elapsed++;
          if (!qsync && !qrst) begin
            m_wait = 0; m_busy = 0;
          end else if (rise) begin
            m_edges_left--;
            if (m_edges_left == 0) begin
              m_wait = 0; m_pulse_left = m_len;
            end
          end else if (m_limit != 0 && m_elapsed == m_limit) begin
            m_wait = 0; m_flag = 1;
          end
        end else if (m_pulse_left > 0) begin
          m_pulse_left--;
        end else if (!qsync && !qrst) begin
          m_busy = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("start_vs_model", 32'(start), 32'((m_busy && m_pulse_left > 0) ? m_mask : 4'h0));
      chk("ack_vs_model",   32'(ack),   32'(m_busy));
      chk("busy_vs_model",  32'(busy),  32'(m_busy));
      chk("tout_vs_model",  32'(tflag), 32'(m_flag));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go_idle();
    qrst = 0; qsync = 0;
    repeat (3) tick();
  endtask

  task automatic spulse();
    ps = 1; tick(); tick();
    ps = 0; tick(); tick(); tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_start", 32'(start), 32'h0);
    chk("reset_ack",   32'(ack),   32'h0);
    chk("reset_busy",  32'(busy),  32'h0);
    chk("reset_tout",  32'(tflag), 32'h0);
    rst_n = 1;
    tick();

    // qrst, len 3, mask 0101
    len = 3; mask = 4'b0101; qrst = 1;
    tick(); chk("qrst_c1", 32'(start), 32'h5); chk("qrst_ack", 32'(ack), 32'h1);
    tick(); chk("qrst_c2", 32'(start), 32'h5);
    tick(); chk("qrst_c3", 32'(start), 32'h5);
    tick(); chk("qrst_end", 32'(start), 32'h0); chk("qrst_ackhold", 32'(ack), 32'h1);
    qrst = 0;
    tick(); chk("qrst_ackdrop", 32'(ack), 32'h0);
    go_idle();

    // qsync, skip 2: third edge fires at m+2
    qsync = 1; skip = 2; tout = 0; len = 2; mask = 4'b1010;
    tick(); chk("sync_busy", 32'(busy), 32'h1);
    spulse(); chk("sync_e1", 32'(start), 32'h0);
    spulse(); chk("sync_e2", 32'(start), 32'h0);
    ps = 1;
    tick(); chk("sync_m", 32'(start), 32'h0);
    tick(); chk("sync_m1", 32'(start), 32'h0);
    ps = 0;
    tick(); chk("sync_m2", 32'(start), 32'ha);
    tick(); chk("sync_m3", 32'(start), 32'ha);
    tick(); chk("sync_end", 32'(start), 32'h0);
    qsync = 0;
    tick(); chk("sync_ackdrop", 32'(ack), 32'h0);
    go_idle();

    // timeout 20, no sync pulse
    qsync = 1; skip = 0; tout = 20; len = 1; mask = 4'hf;
    tick();
    repeat (19) tick();
    chk("tout_pre", 32'(tflag), 32'h0);
    tick(); chk("tout_set", 32'(tflag), 32'h1); chk("tout_ack", 32'(ack), 32'h1);
    chk("tout_nostart", 32'(start), 32'h0);
    qsync = 0;
    tick(); chk("tout_sticky", 32'(tflag), 32'h1); chk("tout_idle", 32'(busy), 32'h0);
    qrst = 1; len = 1; mask = 4'h1; tout = 0;
    tick(); chk("tout_clear", 32'(tflag), 32'h0); chk("tout_qrst", 32'(start), 32'h1);
    go_idle();

    // abort in WSYNC, then simultaneous requests take the qsync path
    qsync = 1; skip = 0; tout = 0;
    tick(); tick();
    qsync = 0;
    tick(); chk("abort_busy", 32'(busy), 32'h0); chk("abort_start", 32'(start), 32'h0);
    qsync = 1; qrst = 1; mask = 4'hf; len = 2;
    tick(); chk("both_busy", 32'(busy), 32'h1); chk("both_nostart", 32'(start), 32'h0);
    go_idle();

    // corners: len 0, mask 0, inputs changing during EXEC
    qrst = 1; len = 0; mask = 4'hf;
    tick(); chk("len0_c1", 32'(start), 32'hf);
    tick(); chk("len0_c2", 32'(start), 32'h0);
    go_idle();
    qrst = 1; len = 2; mask = 4'h0;
    tick(); chk("mask0_ack", 32'(ack), 32'h1); chk("mask0_start", 32'(start), 32'h0);
    go_idle();
    qrst = 1; len = 4; mask = 4'h3;
    tick(); chk("exec_c1", 32'(start), 32'h3);
    mask = 4'hc; len = 1; qrst = 0;
    tick(); chk("exec_c2", 32'(start), 32'h3);
    tick(); chk("exec_c3", 32'(start), 32'h3);
    tick(); chk("exec_c4", 32'(start), 32'h3);
    tick(); chk("exec_ack", 32'(ack), 32'h1); chk("exec_done", 32'(start), 32'h0);
    tick(); chk("exec_idle", 32'(ack), 32'h0);
    go_idle();

    // reset mid-EXEC
    qrst = 1; len = 10; mask = 4'hf;
    tick(); tick(); chk("rst_pre", 32'(start), 32'hf);
    #2 rst_n = 0;
    #1 chk("rst_async_start", 32'(start), 32'h0);
    chk("rst_async_ack", 32'(ack), 32'h0);
    chk("rst_async_busy", 32'(busy), 32'h0);
    qrst = 0;
    tick(); rst_n = 1;
    tick(); chk("rst_idle", 32'(busy), 32'h0);
    qrst = 1; len = 1; mask = 4'h2;
    tick(); chk("rst_recover", 32'(start), 32'h2);
    go_idle();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) qrst = ~qrst;
      if ($urandom_range(0, 13) == 0) qsync = ~qsync;
      if ($urandom_range(0, 3) == 0) ps = ~ps;
      mask = 4'($urandom);
      len  = 8'($urandom_range(0, 6));
      skip = 4'($urandom_range(0, 3));
      tout = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom_range(1, 40));
      tick();
    end
    go_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
